range_arbiter: RTL and testbench

//  Round-robin arbiter sharing one W-bit output datapath among N requesters.
//  It sequences bursts, one owner at a time, with a beat limit per burst.
//  It sits between the subrange datapath instances and a single consumer.

---
 rtl/range_arbiter.sv | 126 ++++++++++++
 tb/tb_range_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/range_arbiter.sv
// range_arbiter
//  Round-robin arbiter that shares one W-bit output datapath among N
//  requesters. A grant covers one burst of at most MAX_BURST beats; one idle
//  cycle always separates two bursts.
//
//  Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req        [N]   per-requester request, held while it has beats
//   lock       [N]   (RANGE_ARB_LOCK_EN only) suppress the burst limit
//   req_data   [N*W] requester i's data at [i*W +: W]
//   out_ready  consumer accepts the beat this cycle
//   gnt        [N]   registered one-hot grant, zero when idle
//   out_valid  shared output carries a valid beat
//   out_data   [W]   shared output data, zero when not valid
//   busy       high while a burst is in progress
//
//  Optional feature macro: RANGE_ARB_LOCK_EN
module range_arbiter #(
   parameter int W         = 4,
   parameter int N         = 3,
   parameter int PW        = 2,
   parameter int MAX_BURST = 4,
   parameter int CW        = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
`ifdef RANGE_ARB_LOCK_EN
   input  logic [N-1:0]   lock,
`endif
   input  logic [N*W-1:0] req_data,
   input  logic           out_ready,
   output logic [N-1:0]   gnt,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           busy
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t              state, state_nx;
   logic [PW-1:0]       ptr, ptr_nx, owner, owner_nx, pick, idx, owner_inc;
   logic [CW-1:0]       beat_cnt, beat_cnt_nx;
   logic [N-1:0]        gnt_nx;
   logic [N-1:0][W-1:0] lanes;
   logic                found, req_own, beat, at_limit, limit_en;

   for (genvar g = 0; g < N; g++) begin : g_lane
      assign lanes[g] = req_data[g*W +: W];
   end

   // Rotating priority scan starting at ptr; wrap is an explicit compare so
   // non-power-of-two N never reaches a nonexistent requester.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = ptr;
      for (int i = 0; i < N; i++) begin
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
      end
   end

   assign busy      = (state == XFER);
   assign req_own   = req[owner];
   assign out_valid = busy & req_own;
   assign out_data  = out_valid ? lanes[owner] : '0;
   assign beat      = out_valid & out_ready;
   assign at_limit  = (beat_cnt == CW'(MAX_BURST-1));
   assign owner_inc = (owner == PW'(N-1)) ? '0 : owner + 1'b1;

`ifdef RANGE_ARB_LOCK_EN
   assign limit_en = ~lock[owner];
`else
   assign limit_en = 1'b1;
`endif

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      owner_nx    = owner;
      beat_cnt_nx = beat_cnt;
      gnt_nx      = gnt;
      case (state)
         IDLE: if (found) begin
            state_nx    = XFER;
            owner_nx    = pick;
            beat_cnt_nx = '0;
            gnt_nx      = '0;
            gnt_nx[pick] = 1'b1;
         end
         XFER: begin
            if (!req_own || (beat && at_limit && limit_en)) begin
               state_nx = IDLE;
               gnt_nx   = '0;
               ptr_nx   = owner_inc;
            end else if (beat && !at_limit) begin
               // under lock the count parks at MAX_BURST-1
               beat_cnt_nx = beat_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         beat_cnt <= '0;
         gnt      <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         owner    <= owner_nx;
         beat_cnt <= beat_cnt_nx;
         gnt      <= gnt_nx;
      end
   end

endmodule

// File: tb/tb_range_arbiter.sv
// tb_range_arbiter
//  Directed scenarios with literal expectations, then randomized traffic.
//  A transaction-level model (owner index or -1, beats taken, next-priority
//  index) predicts gnt/out_valid/out_data/busy, compared every negedge.
module tb_range_arbiter;
   localparam int W = 4, N = 3, PW = 2, MB = 4, CW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] req_data;
   logic           out_ready;
   logic [N-1:0]   gnt;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           busy;

   int vectors = 0;
   int errors  = 0;

   range_arbiter #(.W(W), .N(N), .PW(PW), .MAX_BURST(MB), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req(req),
`ifdef RANGE_ARB_LOCK_EN
      .lock(lock),
`endif
      .req_data(req_data), .out_ready(out_ready),
      .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_owner = -1;  // -1 means no burst in progress
   int m_beats = 0;
   int m_ptr   = 0;

   function automatic int first_req(input int from, input logic [N-1:0] r);
      for (int i = 0; i < N; i++)
         if (r[(from + i) % N]) return (from + i) % N;
      return -1;
   endfunction

   function automatic bit locked(input int o);
`ifdef RANGE_ARB_LOCK_EN
      return lock[o];
`else
      return 1'b0 && (o < 0);
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner <= -1;
         m_beats <= 0;
         m_ptr   <= 0;
      end else if (m_owner < 0) begin
         if (first_req(m_ptr, req) >= 0) begin
            m_owner <= first_req(m_ptr, req);
            m_beats <= 0;
         end
      end else if (!req[m_owner] ||
                   (out_ready && m_beats + 1 >= MB && !locked(m_owner))) begin
         m_owner <= -1;
         m_ptr   <= (m_owner + 1) % N;
      end else if (out_ready) begin
         m_beats <= m_beats + 1;
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] eg;
      logic         ev;
      logic [W-1:0] ed;
      logic         eb;
      eg = '0; ev = 1'b0; ed = '0; eb = 1'b0;
      if (rst && m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ev = req[m_owner];
         ed = ev ? req_data[m_owner*W +: W] : '0;
         eb = 1'b1;
      end
      chk("model_gnt", 32'(gnt), 32'(eg));
      chk("model_valid", 32'(out_valid), 32'(ev));
      chk("model_data", 32'(out_data), 32'(ed));
      chk("model_busy", 32'(busy), 32'(eb));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b0; req = '0; out_ready = 1'b0; lock = '0;
      step();
      rst = 1'b1;
   endtask

   logic [N-1:0] seq2 [16];

   initial begin
      seq2 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
               3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
               3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};

      // reset with all requesting
      rst = 1'b0; req = 3'b111; req_data = 12'h321; out_ready = 1'b1; lock = '0;
      step(); step(); #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b1;

      // round robin, 4 beats each, one bubble between bursts
      step(); #1;
      chk("rr_gnt_0", 32'(gnt), 32'(seq2[0]));
      for (int c = 1; c < 16; c++) begin
         step(); #1;
         chk($sformatf("rr_gnt_%0d", c), 32'(gnt), 32'(seq2[c]));
      end

      // backpressure on owner 1
      reset_dut();
      req = 3'b010; req_data = 12'h0A0; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step(); #1;
         chk("bp_gnt", 32'(gnt), 32'b010);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'hA);
      end
      for (int c = 0; c < 4; c++) begin
         step(); out_ready = 1'b1; #1;
         chk("bp_beat_gnt", 32'(gnt), 32'b010);
      end
      step(); #1;
      chk("bp_end_gnt", 32'(gnt), 0);

      // early release by owner 2
      reset_dut();
      req = 3'b100; req_data = 12'h700; out_ready = 1'b1;
      step(); step(); #1;
      chk("er_gnt", 32'(gnt), 32'b100);
      chk("er_data", 32'(out_data), 32'h7);
      step(); req = 3'b000; #1;
      chk("er_novalid", 32'(out_valid), 0);
      step(); #1;
      chk("er_idle_gnt", 32'(gnt), 0);
      req = 3'b111;
      step(); #1;
      chk("er_ptr_wrap", 32'(gnt), 32'b001);

      // reset during beat 2 of owner 1
      reset_dut();
      req = 3'b010; out_ready = 1'b1;
      step(); step();
      rst = 1'b0; #1;
      chk("mr_gnt", 32'(gnt), 0);
      chk("mr_valid", 32'(out_valid), 0);
      chk("mr_data", 32'(out_data), 0);
      chk("mr_busy", 32'(busy), 0);
      step(); rst = 1'b1; req = 3'b111;
      step(); #1;
      chk("mr_restart", 32'(gnt), 32'b001);

`ifdef RANGE_ARB_LOCK_EN
      // locked owner 0 runs past the burst limit
      reset_dut();
      lock = 3'b001; req = 3'b011; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step(); #1;
         chk("lk_hold", 32'(gnt), 32'b001);
      end
      step(); req = 3'b010;
      step(); #1;
      chk("lk_bubble", 32'(gnt), 0);
      step(); #1;
      chk("lk_next", 32'(gnt), 32'b010);
`endif

      // randomized traffic
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(499) == 0) rst = 1'b0;
         else rst = 1'b1;
         for (int i = 0; i < N; i++)
            if ($urandom_range(5) == 0) req[i] = ~req[i];
         if ($urandom_range(3) == 0) req_data = N*W'($urandom);
         out_ready = ($urandom_range(9) < 7);
         if ($urandom_range(19) == 0) lock = N'($urandom);
      end
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
